// File: rtl/arbiter_rr_pkg.sv
// Shared arbiter types: core count, FSM state encoding and an index helper.
// Hold-limit feature is selected by ARBITER_RR_HOLD_LIMIT_EN (see arbiter_rr).
package arbiter_rr_pkg;

    localparam int NUM_OF_CORES = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Rotating first-set search: lowest set request at or above start, wrapping.
// Purely combinational; used by arbiter_rr for every selection.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         pick,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int W = $clog2(N);

    always_comb begin
        int j;
        logic [W-1:0] jw;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            jw = W'(j);
            if (!found && req[jw]) begin
                found    = 1'b1;
                pick[jw] = 1'b1;
                idx      = jw;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr.sv
// Work-conserving round-robin arbiter with grant lock and registered one-hot grant.
// Define ARBITER_RR_HOLD_LIMIT_EN to force handoff after MAX_HOLD grant cycles.
module arbiter_rr
    import arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ  = NUM_OF_CORES,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         request_vector,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    typedef logic [ID_W-1:0] id_t;
    typedef logic [HC_W-1:0] hc_t;

    localparam hc_t HC_SAT = '1;
`ifdef ARBITER_RR_HOLD_LIMIT_EN
    localparam hc_t HC_MAX = hc_t'(MAX_HOLD);
`endif

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [NUM_REQ-1:0] grant_nx;
    id_t                grant_id_nx;
    id_t                last_id;
    id_t                last_id_nx;
    hc_t                hold_cnt;
    hc_t                hold_cnt_nx;

    id_t                start;
    logic [NUM_REQ-1:0] pick;
    id_t                pick_id;
    logic               found;
    logic               take;

    // Search begins just past the last winner (idle) or the holder (granting).
    assign start = id_t'(wrap_inc(
        int'((state == IDLE) ? last_id : grant_id), NUM_REQ));

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req  (request_vector),
        .start(start),
        .pick (pick),
        .idx  (pick_id),
        .found(found)
    );

    assign grant_valid = |grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            last_id  <= id_t'(NUM_REQ - 1);
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            grant_id <= grant_id_nx;
            hold_cnt <= hold_cnt_nx;
            last_id  <= last_id_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        grant_id_nx = grant_id;
        last_id_nx  = last_id;
        hold_cnt_nx = (hold_cnt == HC_SAT) ? hold_cnt
                                           : hold_cnt + hc_t'(1);
        take        = 1'b0;

        unique case (state)
            IDLE: begin
                take = found;
            end
            GRANT: begin
                if (!request_vector[grant_id]) begin
                    take = found;
                end
`ifdef ARBITER_RR_HOLD_LIMIT_EN
                // At the limit the holder re-wins only if nobody else asks.
                else if (hold_cnt >= HC_MAX) begin
                    take = 1'b1;
                end
`endif
            end
            default: begin
                take = 1'b0;
            end
        endcase

        if (take) begin
            state_nx    = GRANT;
            grant_nx    = pick;
            grant_id_nx = pick_id;
            last_id_nx  = pick_id;
            hold_cnt_nx = hc_t'(1);
        end else if (!found) begin
            state_nx    = IDLE;
            grant_nx    = '0;
            grant_id_nx = '0;
            hold_cnt_nx = '0;
        end
    end

endmodule
